// File: rtl/irq_priority_ctrl_if.sv
// Bus between interrupt sources / core and the irq_priority_ctrl block.
// master: drives source requests, enables and the core return pulse.
// slave : the controller, drives the core request, active id, returns, pending.
interface irq_priority_ctrl_if #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 4
);
  logic [N_SRC-1:0] src_irq_i;
  logic [N_SRC-1:0] src_en_i;
  logic             core_irq_ret_i;
  logic             core_irq_req_o;
  logic [ID_W-1:0]  active_id_o;
  logic [N_SRC-1:0] src_irq_ret_o;
  logic [N_SRC-1:0] pending_o;

  modport master (
    output src_irq_i, src_en_i, core_irq_ret_i,
    input  core_irq_req_o, active_id_o, src_irq_ret_o, pending_o
  );

  modport slave (
    input  src_irq_i, src_en_i, core_irq_ret_i,
    output core_irq_req_o, active_id_o, src_irq_ret_o, pending_o
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller: captures rising edges of N_SRC interrupt
// sources into a pending vector, arbitrates the enabled pending sources and
// services one of them at a time with the core (IDLE -> ACTIVE -> RETIRE).
// Arbitration is fixed priority (lowest index wins) by default; defining
// IRQ_PRIORITY_CTRL_ROUND_ROBIN_EN selects round-robin starting after the
// last granted source.
module irq_priority_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  irq_priority_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RETIRE} state_t;

  state_t           state_reg;
  logic [N_SRC-1:0] src_irq_prev_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] clear_vec;
  logic [N_SRC-1:0] eligible;
  logic             any_eligible;
  logic             ret_accept;
  logic [ID_W-1:0]  winner;
  logic             core_irq_req_reg;
  logic [ID_W-1:0]  active_id_reg;
  logic [N_SRC-1:0] src_irq_ret_reg;

  // The core return only counts while a service is in progress.
  assign ret_accept   = (state_reg == ACTIVE) && bus.core_irq_ret_i;
  assign eligible     = pending_reg & bus.src_en_i;
  assign any_eligible = |eligible;

  // Per-source pending update: a new edge always wins over a clear.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign clear_vec[gi]    = ret_accept && (active_id_reg == ID_W'(gi));
      assign pending_next[gi] = (pending_reg[gi] & ~clear_vec[gi])
                              | (bus.src_irq_i[gi] & ~src_irq_prev_reg[gi]);
    end
  endgenerate

  // Edge capture and pending vector; enables do not gate capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_irq_prev_reg <= '0;
      pending_reg      <= '0;
    end else begin
      src_irq_prev_reg <= bus.src_irq_i;
      pending_reg      <= pending_next;
    end
  end

`ifdef IRQ_PRIORITY_CTRL_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_reg;
  logic            rr_found;
  int              rr_idx;

  // Round-robin search starting one past the last granted source.
  always_comb begin
    winner   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      rr_idx = (int'(rr_ptr_reg) + k) % N_SRC;
      if (!rr_found && eligible[rr_idx]) begin
        winner   = ID_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  // Last-granted pointer moves when a service starts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg <= ID_W'(N_SRC - 1);
    end else if (state_reg == IDLE && any_eligible) begin
      rr_ptr_reg <= winner;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest eligible index.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end
`endif

  // Service FSM with registered core request, active id and return pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= IDLE;
      core_irq_req_reg <= 1'b0;
      active_id_reg    <= '0;
      src_irq_ret_reg  <= '0;
    end else begin
      src_irq_ret_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (any_eligible) begin
            state_reg        <= ACTIVE;
            active_id_reg    <= winner;
            core_irq_req_reg <= 1'b1;
          end
        end
        ACTIVE: begin
          if (bus.core_irq_ret_i) begin
            state_reg        <= RETIRE;
            core_irq_req_reg <= 1'b0;
            src_irq_ret_reg  <= clear_vec;
          end
        end
        RETIRE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg        <= IDLE;
          core_irq_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_irq_req_o = core_irq_req_reg;
  assign bus.active_id_o    = active_id_reg;
  assign bus.src_irq_ret_o  = src_irq_ret_reg;
  assign bus.pending_o      = pending_reg;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench for irq_priority_ctrl (N_SRC=8). The stimulus process
// drives inputs on the falling edge and advances a behavioural model of the
// controller; the model's predictions go into queues that a monitor drains
// after each rising edge. Honours IRQ_PRIORITY_CTRL_ROUND_ROBIN_EN.
module tb_irq_priority_ctrl;
  localparam int N  = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;

  irq_priority_ctrl_if #(.N_SRC(N), .ID_W(IW)) bus ();

  irq_priority_ctrl #(.N_SRC(N), .ID_W(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         req;
    int         id;
    logic [N-1:0] pend;
  } status_t;

  status_t status_q[$];
  int      grant_q[$];
  int      ret_q[$];

  int checks   = 0;
  int failures = 0;

  // Behavioural model: pending flags, previous source levels, service phase.
  bit m_pend[N];
  bit m_prev[N];
  int m_phase;  // 0 waiting, 1 serving, 2 cooldown
  int m_id;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Effect of one rising edge on the model, given the inputs for that edge.
  task automatic model_edge(input bit r, input logic [N-1:0] irq,
                            input logic [N-1:0] en, input bit ret);
    status_t s;
    bit clr[N];
    int w;
    int idx;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_phase = 0;
      m_id    = 0;
      m_ptr   = N - 1;
    end else begin
      w = -1;
      if (m_phase == 0) begin
`ifdef IRQ_PRIORITY_CTRL_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr + k) % N;
          if (w < 0 && m_pend[idx] && en[idx]) w = idx;
        end
`else
        for (int i = 0; i < N; i++) begin
          if (w < 0 && m_pend[i] && en[i]) w = i;
        end
`endif
      end
      for (int i = 0; i < N; i++) clr[i] = 1'b0;
      case (m_phase)
        0: if (w >= 0) begin
             m_phase = 1;
             m_id    = w;
             m_ptr   = w;
             grant_q.push_back(w);
           end
        1: if (ret) begin
             clr[m_id] = 1'b1;
             ret_q.push_back(m_id);
             m_phase = 2;
           end
        default: m_phase = 0;
      endcase
      for (int i = 0; i < N; i++) begin
        m_pend[i] = (m_pend[i] && !clr[i]) || (irq[i] && !m_prev[i]);
        m_prev[i] = irq[i];
      end
    end
    s.req = (m_phase == 1);
    s.id  = m_id;
    for (int i = 0; i < N; i++) s.pend[i] = m_pend[i];
    status_q.push_back(s);
  endtask

  // Drive one cycle of inputs, predict its outcome, wait for the next falling edge.
  task automatic step(input bit r, input logic [N-1:0] irq,
                      input logic [N-1:0] en, input bit ret);
    rst                = r;
    bus.src_irq_i      = irq;
    bus.src_en_i       = en;
    bus.core_irq_ret_i = ret;
    model_edge(r, irq, en, ret);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [N-1:0] en);
    for (int i = 0; i < n; i++) step(1'b0, '0, en, 1'b0);
  endtask

  // Monitor: compares every cycle's status and each grant / return event.
  initial begin
    status_t s;
    logic    prev_req;
    int      e;
    logic [N-1:0] onehot;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (status_q.size() > 0) begin
        s = status_q.pop_front();
        check("core_irq_req", 32'(bus.core_irq_req_o), 32'(s.req));
        check("pending", 32'(bus.pending_o), 32'(s.pend));
        if (s.req) check("active_id_hold", 32'(bus.active_id_o), 32'(s.id));
        if (!s.req && !prev_req && s.pend == '0 && s.id == 0)
          check("active_id_reset", 32'(bus.active_id_o), 32'(s.id));
      end
      if (bus.core_irq_req_o && !prev_req) begin
        if (grant_q.size() == 0) begin
          check("grant_unexpected", 32'(bus.active_id_o), 32'hFFFF_FFFF);
        end else begin
          e = grant_q.pop_front();
          check("grant_id", 32'(bus.active_id_o), 32'(e));
          $display("grant id=%0d at %0t", bus.active_id_o, $time);
        end
      end
      if (bus.src_irq_ret_o != '0) begin
        if (ret_q.size() == 0) begin
          check("ret_unexpected", 32'(bus.src_irq_ret_o), 32'h0);
        end else begin
          e = ret_q.pop_front();
          onehot = '0;
          onehot[e] = 1'b1;
          check("ret_pulse", 32'(bus.src_irq_ret_o), 32'(onehot));
          $display("return id=%0d pulse=%0h at %0t", e, bus.src_irq_ret_o, $time);
        end
      end
      prev_req = bus.core_irq_req_o;
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    logic [N-1:0] irq;
    logic [N-1:0] en;
    bit ret;
    bit r;

    m_phase = 0;
    m_id    = 0;
    m_ptr   = N - 1;

    // Reset.
    step(1'b1, '0, 8'hFF, 1'b0);
    step(1'b1, '0, 8'hFF, 1'b0);

    // Single pulse on source 3, service, return.
    step(1'b0, 8'h08, 8'hFF, 1'b0);
    idle(2, 8'hFF);
    step(1'b0, '0, 8'hFF, 1'b1);
    idle(3, 8'hFF);

    // Simultaneous edges on sources 5 and 2.
    step(1'b0, 8'h24, 8'hFF, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 8'hFF, (i % 3) == 2);
    idle(2, 8'hFF);

    // Capture with all enables off, then enable source 1.
    step(1'b0, 8'h02, 8'h00, 1'b0);
    idle(3, 8'h00);
    step(1'b0, '0, 8'h02, 1'b0);
    step(1'b0, '0, 8'h02, 1'b0);
    step(1'b0, '0, 8'h00, 1'b1);
    idle(3, 8'hFF);

    // New edge on source 6 in the same cycle as its return.
    step(1'b0, 8'h40, 8'hFF, 1'b0);
    idle(2, 8'hFF);
    step(1'b0, 8'h40, 8'hFF, 1'b1);
    idle(4, 8'hFF);
    step(1'b0, '0, 8'hFF, 1'b1);
    idle(3, 8'hFF);

    // Reset while servicing source 4 with it held high, then a stray return.
    step(1'b0, 8'h10, 8'hFF, 1'b0);
    step(1'b0, 8'h10, 8'hFF, 1'b0);
    step(1'b0, 8'h10, 8'hFF, 1'b0);
    step(1'b1, 8'h10, 8'hFF, 1'b1);
    step(1'b0, 8'h10, 8'hFF, 1'b1);
    step(1'b0, '0, 8'hFF, 1'b0);
    step(1'b0, '0, 8'hFF, 1'b1);
    idle(3, 8'hFF);

    // All sources re-pulsed after every service.
    for (int n = 0; n < 10; n++) begin
      step(1'b0, 8'hFF, 8'hFF, 1'b0);
      step(1'b0, '0, 8'hFF, 1'b0);
      step(1'b0, '0, 8'hFF, 1'b1);
      step(1'b0, '0, 8'hFF, 1'b0);
    end
    idle(2, 8'hFF);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      irq = N'($urandom & $urandom & $urandom);
      en  = ($urandom_range(0, 7) == 0) ? N'($urandom) : 8'hFF;
      ret = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 199) == 0);
      step(r, irq, en, ret);
    end

    // Drain and make sure every predicted event was observed.
    idle(4, 8'hFF);
    @(posedge clk);
    #2;
    check("status_q_drained", 32'(status_q.size()), 32'd0);
    check("grant_q_drained", 32'(grant_q.size()), 32'd0);
    check("ret_q_drained", 32'(ret_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
